// File: rtl/cen_fracgen.sv
// Multi-channel fractional clock-enable generator: one phase accumulator per channel,
// carry out of each accumulator becomes a one-cycle enable strobe.
module cen_fracgen #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned ACC_W       = 32,
  parameter int unsigned LOCK_CYCLES = 16,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned LC_W       = $clog2(LOCK_CYCLES + 1)
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  input  logic              sync,
  output logic [NUM_CH-1:0] cen,
  output logic              locked
);

  logic [ACC_W-1:0]  inc_q   [NUM_CH];
  logic [ACC_W-1:0]  inc_d   [NUM_CH];
  logic [ACC_W-1:0]  phase_q [NUM_CH];
  logic [ACC_W-1:0]  phase_d [NUM_CH];
  logic [ACC_W-1:0]  acc_q   [NUM_CH];
  logic [ACC_W-1:0]  acc_d   [NUM_CH];
  logic [ACC_W:0]    sum     [NUM_CH];
  logic [NUM_CH-1:0] cen_q, cen_d;
  logic [LC_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic              locked_q, locked_d;
  logic              wr_valid;
  logic              restart;

  // Writes to channel indices beyond NUM_CH are dropped and do not count as a restart.
  assign wr_valid = cfg_we && (32'(cfg_ch) < NUM_CH);
  assign restart  = wr_valid || sync;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sum[i]     = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
      inc_d[i]   = inc_q[i];
      phase_d[i] = phase_q[i];
      acc_d[i]   = sum[i][ACC_W-1:0];
      cen_d[i]   = sum[i][ACC_W];
      if (wr_valid && (32'(cfg_ch) == i)) begin
        inc_d[i]   = cfg_inc;
        phase_d[i] = cfg_phase;
        acc_d[i]   = cfg_phase;
        cen_d[i]   = 1'b0;
      end else if (sync) begin
        acc_d[i] = phase_q[i];
        cen_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (restart) begin
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end else begin
      if (lock_cnt_q != LC_W'(LOCK_CYCLES)) begin
        lock_cnt_d = lock_cnt_q + 1'b1;
      end
      locked_d = (lock_cnt_q == LC_W'(LOCK_CYCLES - 1)) || locked_q;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        inc_q[i]   <= '0;
        phase_q[i] <= '0;
        acc_q[i]   <= '0;
      end
      cen_q      <= '0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      inc_q      <= inc_d;
      phase_q    <= phase_d;
      acc_q      <= acc_d;
      cen_q      <= cen_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign cen    = cen_q;
  assign locked = locked_q;

endmodule
